// File: rtl/fb_pkg.sv
// Shared defaults, FSM state type and pixel beat layout for the framebuffer writer.
// Optional double buffering is selected by defining FB_DOUBLE_BUFFER_EN.
package fb_pkg;

    localparam int FB_H_RES   = 800;
    localparam int FB_V_RES   = 600;
    localparam int FB_COORD_W = 11;
    localparam int FB_DATA_W  = 8;
    localparam int FB_ADDR_W  = 20;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } fb_state_t;

    typedef struct packed {
        logic [FB_COORD_W-1:0] x;
        logic [FB_COORD_W-1:0] y;
        logic [FB_DATA_W-1:0]  data;
        logic                  draw;
    } pixel_beat_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Two-stage address pipe: row base multiply, then column add, bounds check and BRAM write drive.
// The buffer-select bit is supplied by the caller (tied low when FB_DOUBLE_BUFFER_EN is undefined).
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int H_RES   = FB_H_RES,
    parameter int V_RES   = FB_V_RES,
    parameter int COORD_W = FB_COORD_W,
    parameter int DATA_W  = FB_DATA_W,
    parameter int ADDR_W  = FB_ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [DATA_W-1:0]  pix_data,
    input  logic               pix_draw,
    input  logic               write_buf,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               drop,
    output logic               occupied
);

    localparam int PROD_W = COORD_W + 10;
    localparam int LIN_W  = ADDR_W - 1;
    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_RES);
    localparam logic [PROD_W-1:0]  H_MUL = PROD_W'(H_RES);

    logic               s2_valid;
    logic [PROD_W-1:0]  s2_row;
    logic [COORD_W-1:0] s2_x;
    logic [COORD_W-1:0] s2_y;
    logic [DATA_W-1:0]  s2_data;
    logic               s2_draw;
    logic               s3_valid;

    logic [LIN_W-1:0]   lin_addr;
    logic               in_bounds;
    logic               do_write;

    // The full row product is kept; only the final linear address is cut to the buffer size.
    always_comb begin
        lin_addr  = LIN_W'(s2_row) + LIN_W'(s2_x);
        in_bounds = (s2_x < X_LIM) && (s2_y < Y_LIM);
        do_write  = s2_valid && s2_draw && in_bounds;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_row   <= '0;
            s2_x     <= '0;
            s2_y     <= '0;
            s2_data  <= '0;
            s2_draw  <= 1'b0;
            s3_valid <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            drop     <= 1'b0;
        end else begin
            s2_valid <= pix_valid;
            if (pix_valid) begin
                s2_row  <= PROD_W'(pix_y) * H_MUL;
                s2_x    <= pix_x;
                s2_y    <= pix_y;
                s2_data <= pix_data;
                s2_draw <= pix_draw;
            end
            s3_valid <= s2_valid;
            wr_en    <= do_write;
            drop     <= s2_valid && s2_draw && !in_bounds;
            if (do_write) begin
                wr_addr <= {write_buf, lin_addr};
                wr_data <= s2_data;
            end
        end
    end

    assign occupied = s2_valid | s3_valid;

endmodule

// File: rtl/framebuffer_writer.sv
// Rasterizer pixel sink: accepts beats, writes the framebuffer, counts frames after draining.
// Define FB_DOUBLE_BUFFER_EN to enable vsync-synchronised buffer swapping.
//
//  state | meaning
//  RUN   | accepting beats; frame_end rising edge ends the frame
//  DRAIN | input closed, waiting for S1..S3 to empty
//  SWAP  | waiting for vsync to flip display_buf (double-buffer build only)
module framebuffer_writer
    import fb_pkg::*;
#(
    parameter int H_RES   = FB_H_RES,
    parameter int V_RES   = FB_V_RES,
    parameter int COORD_W = FB_COORD_W,
    parameter int DATA_W  = FB_DATA_W,
    parameter int ADDR_W  = FB_ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_draw,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               frame_end,
    input  logic               vsync,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [DATA_W-1:0]  fb_din,
    output logic               display_buf,
    output logic [15:0]        frame_count,
    output logic [15:0]        drop_count,
    output logic               busy
);

    fb_state_t   state;
    fb_state_t   state_nxt;
    logic        ready_en;
    logic        fe_q;
    logic        fe_edge;
    logic        accept;
    pixel_beat_t s1_beat;
    logic        s1_valid;
    logic        gen_occupied;
    logic        gen_drop;
    logic        pipe_empty;
    logic        count_go;
    logic        write_buf;

    assign in_ready   = ready_en && (state == ST_RUN);
    assign accept     = in_valid && in_ready;
    assign fe_edge    = frame_end && !fe_q;
    assign pipe_empty = !s1_valid && !gen_occupied;
    assign busy       = (state != ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_go  = 1'b0;
        case (state)
            ST_RUN: begin
                if (fe_edge) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
`ifdef FB_DOUBLE_BUFFER_EN
                    state_nxt = ST_SWAP;
`else
                    state_nxt = ST_RUN;
                    count_go  = 1'b1;
`endif
                end
            end
            ST_SWAP: begin
`ifdef FB_DOUBLE_BUFFER_EN
                if (vsync) begin
                    state_nxt = ST_RUN;
                    count_go  = 1'b1;
                end
`else
                state_nxt = ST_RUN;
`endif
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // fe_q resets high so a rasterizer already idle at reset does not look like a finished frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_en    <= 1'b0;
            fe_q        <= 1'b1;
            s1_valid    <= 1'b0;
            s1_beat     <= '0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            ready_en <= 1'b1;
            fe_q     <= frame_end;
            s1_valid <= accept;
            if (accept) begin
                s1_beat <= '{x: in_x, y: in_y, data: in_data, draw: in_draw};
            end
            if (count_go) frame_count <= frame_count + 16'd1;
            if (gen_drop) drop_count <= sat_inc16(drop_count);
        end
    end

`ifdef FB_DOUBLE_BUFFER_EN
    logic disp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q <= 1'b0;
        end else if (count_go) begin
            disp_q <= ~disp_q;
        end
    end

    assign display_buf = disp_q;
    assign write_buf   = ~disp_q;
`else
    logic unused_vsync;

    assign unused_vsync = vsync;
    assign display_buf  = 1'b0;
    assign write_buf    = 1'b0;
`endif

    fb_addr_gen #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .COORD_W (COORD_W),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .pix_valid (s1_valid),
        .pix_x     (s1_beat.x),
        .pix_y     (s1_beat.y),
        .pix_data  (s1_beat.data),
        .pix_draw  (s1_beat.draw),
        .write_buf (write_buf),
        .wr_en     (fb_we),
        .wr_addr   (fb_addr),
        .wr_data   (fb_din),
        .drop      (gen_drop),
        .occupied  (gen_occupied)
    );

endmodule

// File: tb/tb_framebuffer_writer.sv
// Scoreboard bench for framebuffer_writer: directed frame/reset scenarios plus random pixel traffic.
module tb_framebuffer_writer;

    localparam int H = 800;
    localparam int V = 600;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] in_x = '0;
    logic [10:0] in_y = '0;
    logic [7:0]  in_data = '0;
    logic        in_draw = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        frame_end = 1'b0;
    logic        vsync = 1'b0;
    logic        fb_we;
    logic [19:0] fb_addr;
    logic [7:0]  fb_din;
    logic        display_buf;
    logic [15:0] frame_count;
    logic [15:0] drop_count;
    logic        busy;

    framebuffer_writer dut (
        .clk         (clk),
        .reset       (reset),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_data     (in_data),
        .in_draw     (in_draw),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .frame_end   (frame_end),
        .vsync       (vsync),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_din      (fb_din),
        .display_buf (display_buf),
        .frame_count (frame_count),
        .drop_count  (drop_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic exp_disp = 1'b0;
    int   exp_frames = 0;
    int   exp_drop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Expected write: linear address in the hidden buffer, visible 3 cycles after the accept cycle.
    task automatic model_beat(input int x, input int y, input int d, input bit dr);
        exp_t e;
        int   wb;
        if (dr) begin
            if (x < H && y < V) begin
`ifdef FB_DOUBLE_BUFFER_EN
                wb = exp_disp ? 0 : 1;
`else
                wb = 0;
`endif
                e.addr = 20'(wb * (1 << 19) + y * H + x);
                e.data = 8'(d);
                e.cyc  = cyc + 3;
                sb.push_back(e);
            end else if (exp_drop < 65535) begin
                exp_drop++;
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            check("missed_write", 32'(e.addr), 32'hFFFFFFFF);
        end
        if (fb_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(fb_addr), 32'hFFFFFFFF);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(fb_addr), 32'(e.addr));
                check("wr_data", 32'(fb_din), 32'(e.data));
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send(input int x, input int y, input int d, input bit dr);
        int waited = 0;
        in_x     = 11'(x);
        in_y     = 11'(y);
        in_data  = 8'(d);
        in_draw  = dr;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            model_beat(x, y, d, dr);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        @(posedge clk);
        #1;
        vsync = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"}, 32'(fb_we), 32'd0);
        check({tag, "_addr"}, 32'(fb_addr), 32'd0);
        check({tag, "_din"}, 32'(fb_din), 32'd0);
        check({tag, "_disp"}, 32'(display_buf), 32'd0);
        check({tag, "_frames"}, 32'(frame_count), 32'd0);
        check({tag, "_drops"}, 32'(drop_count), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int x, y, d;
        bit dr;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_first_cycle", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // single pixel, latency and buffer bit
        send(5, 2, 8'h3C, 1'b1);
        idle(5);
        check("t1_drained", sb.size(), 0);

        // opposite corners back to back
        send(799, 599, 8'hA5, 1'b1);
        send(0, 0, 8'h5A, 1'b1);
        idle(5);

        // out of bounds drop and non-drawing beat
        send(800, 10, 8'h11, 1'b1);
        send(10, 10, 8'h22, 1'b0);
        idle(6);
        check("t3_drop", 32'(drop_count), 32'd1);

        for (int i = 0; i < 300; i++) begin
            x  = $urandom_range(0, 850);
            y  = $urandom_range(0, 650);
            d  = $urandom_range(0, 255);
            dr = ($urandom_range(0, 3) != 0);
            send(x, y, d, dr);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(6);
        check("rand_drop", 32'(drop_count), 32'(exp_drop));
        check("rand_drained", sb.size(), 0);
        check("rand_busy", 32'(busy), 32'd0);

        // frame end coincident with the last beat of the frame
        send(100, 1, 8'h01, 1'b1);
        send(101, 1, 8'h02, 1'b1);
        send(102, 1, 8'h03, 1'b1);
        frame_end = 1'b1;
        send(103, 1, 8'h04, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_ready_low", 32'(in_ready), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
`ifdef FB_DOUBLE_BUFFER_EN
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_wait_busy", 32'(busy), 32'd1);
        check("t4_wait_disp", 32'(display_buf), 32'd0);
        check("t4_wait_frames", 32'(frame_count), 32'd0);
        check("t4_drained", sb.size(), 0);
        @(posedge clk);
        #1;
        pulse_vsync();
        exp_disp = 1'b1;
`else
        wait_idle(20);
`endif
        exp_frames = 1;
        @(negedge clk);
        check("t4_disp", 32'(display_buf), 32'(exp_disp));
        check("t4_frames", 32'(frame_count), 32'(exp_frames));
        check("t4_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // vsync during drain ignored, frame_end edge during drain lost
        frame_end = 1'b0;
        idle(2);
        send(1, 1, 8'h77, 1'b1);
        in_valid  = 1'b0;
        frame_end = 1'b1;
        @(posedge clk);
        #1;
        vsync     = 1'b1;
        frame_end = 1'b0;
        @(posedge clk);
        #1;
        vsync     = 1'b0;
        frame_end = 1'b1;
        @(posedge clk);
        #1;
`ifdef FB_DOUBLE_BUFFER_EN
        repeat (30) @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_swap_busy", 32'(busy), 32'd1);
        check("t5_swap_disp", 32'(display_buf), 32'd1);
        check("t5_swap_frames", 32'(frame_count), 32'd1);
        @(posedge clk);
        #1;
        pulse_vsync();
        exp_disp = 1'b0;
`else
        wait_idle(20);
`endif
        exp_frames = 2;
        @(negedge clk);
        check("t5_disp", 32'(display_buf), 32'(exp_disp));
        check("t5_frames", 32'(frame_count), 32'(exp_frames));
        idle(5);
        @(negedge clk);
        check("t5_no_requeue_busy", 32'(busy), 32'd0);
        check("t5_no_requeue_frames", 32'(frame_count), 32'(exp_frames));
        @(posedge clk);
        #1;

        // reset with two beats in flight
        send(3, 3, 8'h31, 1'b1);
        send(4, 4, 8'h32, 1'b1);
        in_valid = 1'b0;
        reset    = 1'b1;
        sb.delete();
        exp_disp   = 1'b0;
        exp_frames = 0;
        exp_drop   = 0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("t6");
        @(posedge clk);
        #1 reset = 1'b0;
        idle(8);
        @(negedge clk);
        check("t6_ready", 32'(in_ready), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_we", 32'(fb_we), 32'd0);
        @(posedge clk);
        #1;

        send(7, 8, 8'h9E, 1'b1);
        idle(6);
        check("final_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
